// File: rtl/uart_image_loader.sv
// uart_image_loader: UART receive front end in the uart_sampling_clk domain.
// Synchronises and oversamples rx, deframes bytes, parses a one-byte command
// header, then gathers NUM_PIXELS pixel bytes into a flat image vector that is
// presented together with a held start strobe and the train flag.
// Optional feature: define UART_PARITY_EN to expect an even-parity bit between
// the data bits and the stop bit.
module uart_image_loader #(
  parameter int         NUM_PIXELS = 784,
  parameter int         OVERSAMPLE = 16,
  parameter int         START_HOLD = 8,
  parameter logic [7:0] HDR_CLASS  = 8'hA5,
  parameter logic [7:0] HDR_TRAIN  = 8'h5A,
  localparam int        IMG_SZ     = NUM_PIXELS * 8
) (
  input  logic              uart_sampling_clk,
  input  logic              rst,
  input  logic              rx,
  output logic              start,
  output logic              train,
  output logic [IMG_SZ-1:0] image,
  output logic              busy,
  output logic              frame_err
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int CNT_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int HOLD_W = $clog2(START_HOLD);

  localparam logic [TICK_W-1:0] HALF_TICK   = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_TICK   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  LAST_PIX    = CNT_W'(NUM_PIXELS - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(START_HOLD - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic {F_HDR, F_PIX} frame_state_t;

  // Receiver state
  logic [1:0]        rx_sync_q;
  logic              rx_s;
  rx_state_t         rx_state_q;
  logic [TICK_W-1:0] tick_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              par_err_q;
  logic              byte_valid_q;
  logic              byte_err_q;

  // Frame assembly state
  frame_state_t      frame_state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hdr_train_q;
  logic [IMG_SZ-1:0] shadow_q;
  logic [IMG_SZ-1:0] shadow_d;
  logic [IMG_SZ-1:0] image_q;
  logic              train_q;
  logic              start_q;
  logic [HOLD_W-1:0] hold_q;
  logic              frame_err_q;

  assign rx_s = rx_sync_q[1];

  // Two-flop synchroniser for the asynchronous serial line (idles high)
  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) rx_sync_q <= 2'b11;
    else     rx_sync_q <= {rx_sync_q[0], rx};
  end

  // Byte deframer: mid-bit sampling driven by an oversample tick counter
  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          tick_q <= '0;
          if (!rx_s) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (tick_q == HALF_TICK) begin
            tick_q     <= '0;
            bit_q      <= '0;
            par_err_q  <= 1'b0;
            // A line that is high again at mid start bit was only a glitch
            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (tick_q == FULL_TICK) begin
            tick_q  <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state_q <= RX_PARITY;
`else
              rx_state_q <= RX_STOP;
`endif
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (tick_q == FULL_TICK) begin
            tick_q     <= '0;
            // Even parity: data bits plus parity bit hold an even count of ones
            par_err_q  <= (^shift_q) ^ rx_s;
            rx_state_q <= RX_STOP;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (tick_q == FULL_TICK) begin
            tick_q     <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_s && !par_err_q) byte_valid_q <= 1'b1;
            else                    byte_err_q   <= 1'b1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Shadow image with the incoming byte merged at the current pixel slot
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[8*cnt_q +: 8] = shift_q;
  end

  // Frame FSM: header parse, pixel collection, image publish and start hold
  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      frame_state_q <= F_HDR;
      cnt_q         <= '0;
      hdr_train_q   <= 1'b0;
      shadow_q      <= '0;
      image_q       <= '0;
      train_q       <= 1'b0;
      start_q       <= 1'b0;
      hold_q        <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (start_q) begin
        if (hold_q == '0) start_q <= 1'b0;
        else              hold_q  <= hold_q - 1'b1;
      end
      case (frame_state_q)
        F_HDR: begin
          if (byte_valid_q && (shift_q == HDR_CLASS || shift_q == HDR_TRAIN)) begin
            hdr_train_q   <= (shift_q == HDR_TRAIN);
            cnt_q         <= '0;
            frame_state_q <= F_PIX;
          end else if (byte_err_q) begin
            frame_err_q <= 1'b1;
          end
        end
        F_PIX: begin
          if (byte_valid_q) begin
            shadow_q <= shadow_d;
            if (cnt_q == LAST_PIX) begin
              // Publishing overrides the hold countdown, so back-to-back
              // completions keep start high with a fresh hold period
              frame_state_q <= F_HDR;
              image_q       <= shadow_d;
              train_q       <= hdr_train_q;
              start_q       <= 1'b1;
              hold_q        <= HOLD_RELOAD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (byte_err_q) begin
            frame_state_q <= F_HDR;
            cnt_q         <= '0;
            frame_err_q   <= 1'b1;
          end
        end
        default: frame_state_q <= F_HDR;
      endcase
    end
  end

  assign start     = start_q;
  assign train     = train_q;
  assign image     = image_q;
  assign busy      = (frame_state_q == F_PIX);
  assign frame_err = frame_err_q;

endmodule
